// File: rtl/periodic_sender_if.sv
// NAP data-stream link: single-beat messages with valid/ready handshake.
// The tx modport is the source side, rx the sink side.
interface t_DATA_STREAM;
  logic         valid;
  logic         ready;
  logic [255:0] data;
  logic [3:0]   dest_id;
  logic         sop;
  logic         eop;

  modport tx (output valid, data, dest_id, sop, eop, input ready);
  modport rx (input valid, data, dest_id, sop, eop, output ready);
endinterface

// File: rtl/periodic_sender.sv
// Periodic/button-triggered message source: each trigger bumps an 8-bit count,
// queues it in a small FIFO, and a two-state TX machine streams it onto the NAP.
module periodic_sender #(
  parameter logic [31:0] PERIOD_CYCLES = 32'd100_000_000,
  parameter int          DEST_ID       = 0,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       button_n,
  output logic [7:0] count,
  output logic [7:0] dropped,
  t_DATA_STREAM.tx   nap
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, next_state;
  logic             btn_sync1, btn_sync2, pressed_d, btn_pulse;
  logic [31:0]      timer;
  logic             tick, trigger;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fill;
  logic             empty, full, push, pop;
  logic [7:0]       out_data;

  // Synchronizers idle at the released level; the press pulse is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync1 <= 1'b1;
      btn_sync2 <= 1'b1;
      pressed_d <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      btn_sync1 <= button_n;
      btn_sync2 <= btn_sync1;
      pressed_d <= ~btn_sync2;
      btn_pulse <= ~btn_sync2 & ~pressed_d;
    end
  end

  assign tick = enable && (timer == PERIOD_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (!enable || tick)
      timer <= '0;
    else
      timer <= timer + 32'd1;
  end

  assign trigger = tick | btn_pulse;
  assign empty   = (fill == '0);
  assign full    = (fill == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = !empty && ((state == IDLE) || nap.ready);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push    = trigger && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      dropped <= '0;
    end else if (trigger) begin
      count <= count + 8'd1;
      if (!push && dropped != 8'hFF)
        dropped <= dropped + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= count + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out_data <= '0;
    else if (pop)
      out_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = SEND;
      SEND:    if (nap.ready && empty) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The beat is held in out_data, so valid depends only on state.
  always_comb begin
    nap.valid      = (state == SEND);
    nap.sop        = (state == SEND);
    nap.eop        = (state == SEND);
    nap.dest_id    = 4'(DEST_ID);
    nap.data       = '0;
    nap.data[7:0]  = out_data;
  end

endmodule

// File: tb/tb_periodic_sender.sv
// Directed bench for periodic_sender: timer, back-pressure, button, collisions,
// saturation/wrap and mid-transfer reset, with hand-computed expectations.
module tb_periodic_sender;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       button_n = 1'b1;
  logic [7:0] count, dropped;

  t_DATA_STREAM nap_bus();

  int         assert_count = 0;
  int         fail_count = 0;
  logic [7:0] beats[$];

  periodic_sender #(
    .PERIOD_CYCLES (32'd10),
    .DEST_ID       (5),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .button_n (button_n),
    .count    (count),
    .dropped  (dropped),
    .nap      (nap_bus.tx)
  );

  always #5 clk = ~clk;

  // Records every beat that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    if (nap_bus.valid && nap_bus.ready)
      beats.push_back(nap_bus.data[7:0]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic btn_n);
    enable        = en;
    nap_bus.ready = rdy;
    button_n      = btn_n;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    beats.delete();
  endtask

  initial begin
    nap_bus.ready = 1'b0;

    // Timer basic
    applyStimulus(1'b1, 1'b1, 1'b1);
    doReset();
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_dropped", 32'(dropped), 32'd0);
    checkOutput("reset_valid", 32'(nap_bus.valid), 32'd0);
    checkOutput("reset_data", 32'(nap_bus.data[7:0]), 32'd0);
    checkOutput("reset_sop", 32'(nap_bus.sop), 32'd0);
    step(9);
    checkOutput("tmr_count_e9", 32'(count), 32'd0);
    step(1);
    checkOutput("tmr_count_e10", 32'(count), 32'd1);
    checkOutput("tmr_valid_e10", 32'(nap_bus.valid), 32'd0);
    step(1);
    checkOutput("tmr_valid_e11", 32'(nap_bus.valid), 32'd1);
    checkOutput("tmr_data_e11", 32'(nap_bus.data[7:0]), 32'd1);
    checkOutput("tmr_upper_zero", 32'(|nap_bus.data[255:8]), 32'd0);
    checkOutput("tmr_sop", 32'(nap_bus.sop), 32'd1);
    checkOutput("tmr_eop", 32'(nap_bus.eop), 32'd1);
    checkOutput("tmr_dest", 32'(nap_bus.dest_id), 32'd5);
    step(1);
    checkOutput("tmr_valid_e12", 32'(nap_bus.valid), 32'd0);
    step(9);
    checkOutput("tmr_data_e21", 32'(nap_bus.data[7:0]), 32'd2);
    step(10);
    checkOutput("tmr_data_e31", 32'(nap_bus.data[7:0]), 32'd3);
    step(2);
    checkOutput("tmr_beats", 32'(beats.size()), 32'd3);

    // Back-pressure: one beat on the wire, four buffered, sixth dropped
    applyStimulus(1'b1, 1'b0, 1'b1);
    doReset();
    step(11);
    checkOutput("bp_data_e11", 32'(nap_bus.data[7:0]), 32'd1);
    step(49);
    checkOutput("bp_count_e60", 32'(count), 32'd6);
    checkOutput("bp_dropped_e60", 32'(dropped), 32'd1);
    checkOutput("bp_valid_held", 32'(nap_bus.valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(5);
    checkOutput("bp_data_held", 32'(nap_bus.data[7:0]), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_b2b_valid", 32'(nap_bus.valid), 32'd1);
      checkOutput("bp_b2b_data", 32'(nap_bus.data[7:0]), 32'(i + 1));
      step(1);
    end
    checkOutput("bp_drain_idle", 32'(nap_bus.valid), 32'd0);
    checkOutput("bp_final_count", 32'(count), 32'd6);

    // Button: one beat per press, timer disabled
    applyStimulus(1'b0, 1'b1, 1'b1);
    doReset();
    step(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(3);
    checkOutput("btn_count_e3", 32'(count), 32'd0);
    step(1);
    checkOutput("btn_count_e4", 32'(count), 32'd1);
    checkOutput("btn_valid_e4", 32'(nap_bus.valid), 32'd0);
    step(1);
    checkOutput("btn_valid_e5", 32'(nap_bus.valid), 32'd1);
    checkOutput("btn_data_e5", 32'(nap_bus.data[7:0]), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(20);
    checkOutput("btn_beats_short", 32'(beats.size()), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(100);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(20);
    checkOutput("btn_beats_long", 32'(beats.size()), 32'd2);
    checkOutput("btn_long_data", 32'(beats[1]), 32'd2);
    checkOutput("btn_long_count", 32'(count), 32'd2);

    // Button edge coinciding with a timer tick gives one trigger
    applyStimulus(1'b1, 1'b1, 1'b1);
    doReset();
    step(6);
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(4);
    checkOutput("sim_count_e10", 32'(count), 32'd1);
    step(9);
    checkOutput("sim_count_e19", 32'(count), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(1);
    checkOutput("sim_count_e20", 32'(count), 32'd2);
    step(3);
    checkOutput("sim_beats", 32'(beats.size()), 32'd2);
    checkOutput("sim_beat0", 32'(beats[0]), 32'd1);

    // Saturation: 300 triggers with the sink stalled
    applyStimulus(1'b1, 1'b0, 1'b1);
    doReset();
    step(3000);
    checkOutput("sat_dropped", 32'(dropped), 32'd255);
    checkOutput("sat_count", 32'(count), 32'd44);
    checkOutput("sat_data_held", 32'(nap_bus.data[7:0]), 32'd1);

    // Count wrap 255 -> 0 observed on the wire
    applyStimulus(1'b1, 1'b1, 1'b1);
    doReset();
    step(2560);
    checkOutput("wrap_count", 32'(count), 32'd0);
    step(1);
    checkOutput("wrap_valid", 32'(nap_bus.valid), 32'd1);
    checkOutput("wrap_data", 32'(nap_bus.data[7:0]), 32'd0);
    step(2);
    checkOutput("wrap_beats", 32'(beats.size()), 32'd256);
    if (beats.size() == 256) begin
      checkOutput("wrap_beat254", 32'(beats[254]), 32'd255);
      checkOutput("wrap_beat255", 32'(beats[255]), 32'd0);
    end
    checkOutput("wrap_dropped", 32'(dropped), 32'd0);

    // Reset mid-transfer with three entries queued
    applyStimulus(1'b1, 1'b0, 1'b1);
    doReset();
    step(40);
    checkOutput("rst_pre_valid", 32'(nap_bus.valid), 32'd1);
    checkOutput("rst_pre_count", 32'(count), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(nap_bus.valid), 32'd0);
    checkOutput("rst_async_count", 32'(count), 32'd0);
    checkOutput("rst_async_dropped", 32'(dropped), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    doReset();
    step(10);
    checkOutput("rst_post_count", 32'(count), 32'd1);
    step(1);
    checkOutput("rst_post_valid", 32'(nap_bus.valid), 32'd1);
    checkOutput("rst_post_data", 32'(nap_bus.data[7:0]), 32'd1);
    step(2);
    checkOutput("rst_post_beats", 32'(beats.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
